// File: rtl/scan_ctrl.sv
// Refresh scanner for an 8-digit multiplexed 7-segment display.
// Each digit slot is a blanking gap (all anodes off) followed by the drive window.
module scan_ctrl #(
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] dig_en,
    output logic [2:0] select,
    output logic [7:0] anode,
    output logic       scan_tick,
    output logic       frame_done
);

    localparam int MAX_AB  = (DIV_CNT > BLANK_CYC) ? DIV_CNT : BLANK_CYC;
    localparam int CNT_MAX = (MAX_AB > 2) ? MAX_AB : 2;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit            NO_BLANK   = (BLANK_CYC == 0);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    select_q, select_d;
    logic          scan_tick_q, scan_tick_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        select_d     = select_q;
        scan_tick_d  = 1'b0;
        frame_done_d = 1'b0;
        // Dropping enable wins over a slot boundary, so select is held as-is.
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = NO_BLANK ? DRIVE : BLANK;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = DRIVE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d        = '0;
                        select_d     = select_q + 3'd1;
                        scan_tick_d  = 1'b1;
                        frame_done_d = (select_q == 3'd7);
                        state_d      = NO_BLANK ? DRIVE : BLANK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            select_q     <= '0;
            scan_tick_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            select_q     <= select_d;
            scan_tick_q  <= scan_tick_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Decoded from registered state so a dig_en change shows up immediately.
    always_comb begin
        anode = '1;
        if (state_q == DRIVE && dig_en[select_q]) begin
            anode = ~(8'b1 << select_q);
        end
    end

    assign select     = select_q;
    assign scan_tick  = scan_tick_q;
    assign frame_done = frame_done_q;

endmodule
